// File: rtl/dmem_responder.sv
// Data-side responder: word-organised RAM with byte/half/word access plus an MMIO window
// (LED, STATUS, and CNT/CMP/irq when DMEM_TIMER_EN is defined).
module dmem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] dout,
  output logic [31:0] led,
  output logic        irq,
  output logic        err
);

  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 1 << ADDR_W;

  localparam logic [3:0] OFF_LED = 4'h0;
  localparam logic [3:0] OFF_CNT = 4'h4;
  localparam logic [3:0] OFF_STS = 4'h8;
  localparam logic [3:0] OFF_CMP = 4'hC;

  typedef struct packed {
    logic word;
    logic half;
    logic byt;
    logic sext;
    logic rsvd;
  } acc_t;

  acc_t                     acc;
  logic                     is_mmio;
  logic [3:0]               off;
  logic [ADDR_W-1:0]        idx;
  logic [NUM_LANES-1:0]     be;
  logic [NUM_LANES-1:0][7:0] wdata;
  logic [NUM_LANES-1:0][7:0] rdata;
  logic [15:0]              ld_half;
  logic [7:0]               ld_byte;
  logic [31:0]              ram_ld;
  logic [31:0]              mmio_rd;
  logic                     we, ram_we, mmio_we;
  logic                     st_ev, st_clr;
  logic                     st_sticky;
  logic [7:0]               st_cnt, st_base;

  assign is_mmio = addr[31];
  assign off     = addr[3:0];
  assign idx     = addr[ADDR_W+1:2];

  always_comb begin
    acc = '0;
    case (dm_ctrl)
      3'b000:  acc.word = 1'b1;
      3'b001:  begin acc.half = 1'b1; acc.sext = 1'b1; end
      3'b010:  acc.half = 1'b1;
      3'b011:  begin acc.byt = 1'b1; acc.sext = 1'b1; end
      3'b100:  acc.byt = 1'b1;
      default: acc.rsvd = 1'b1;
    endcase
  end

  assign err = acc.rsvd
             | (acc.word && addr[1:0] != 2'b00)
             | (acc.half && addr[0])
             | (is_mmio && !acc.word);

  assign we      = mem_w & ~err;
  assign ram_we  = we & ~is_mmio;
  assign mmio_we = we & is_mmio;

  // Stores replicate the narrow datum across lanes; byte enables pick the target lane.
  always_comb begin
    be    = '0;
    wdata = din;
    if (acc.byt) begin
      be[addr[1:0]] = 1'b1;
      wdata         = {NUM_LANES{din[7:0]}};
    end else if (acc.half) begin
      be    = addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{din[15:0]}};
    end else if (acc.word) begin
      be = '1;
    end
  end

  genvar g;
  for (g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] ram [DEPTH];
    always_ff @(posedge clk)
      if (ram_we && be[g]) ram[idx] <= wdata[g];
    assign rdata[g] = ram[idx];
  end

  always_comb begin
    ld_half = addr[1] ? rdata[3:2] : rdata[1:0];
    ld_byte = rdata[addr[1:0]];
    ram_ld  = rdata;
    if (acc.half)
      ram_ld = {{16{acc.sext & ld_half[15]}}, ld_half};
    else if (acc.byt)
      ram_ld = {{24{acc.sext & ld_byte[7]}}, ld_byte};
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] cnt, cmp;
  logic        wr_cnt, wr_cmp;

  assign wr_cnt = mmio_we && off == OFF_CNT;
  assign wr_cmp = mmio_we && off == OFF_CMP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      cmp <= 32'hFFFF_FFFF;
      irq <= 1'b0;
    end else begin
      cnt <= wr_cnt ? din : cnt + 32'd1;
      if (wr_cmp) cmp <= din;
      // A CMP write takes precedence over a coincident match.
      if (wr_cmp)           irq <= 1'b0;
      else if (cnt == cmp)  irq <= 1'b1;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_LED: mmio_rd = led;
      OFF_STS: mmio_rd = {16'h0, st_cnt, 7'h0, st_sticky};
`ifdef DMEM_TIMER_EN
      OFF_CNT: mmio_rd = cnt;
      OFF_CMP: mmio_rd = cmp;
`endif
      default: mmio_rd = '0;
    endcase
  end

  assign dout = err ? 32'h0 : (is_mmio ? mmio_rd : ram_ld);

  // A faulting store aimed at STATUS still clears it first, so the new event counts from zero.
  assign st_ev   = mem_w & err;
  assign st_clr  = mem_w & is_mmio & (off == OFF_STS);
  assign st_base = st_clr ? 8'h00 : st_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led       <= '0;
      st_sticky <= 1'b0;
      st_cnt    <= '0;
    end else begin
      if (mmio_we && off == OFF_LED) led <= din;
      if (st_ev) begin
        st_sticky <= 1'b1;
        st_cnt    <= (st_base == 8'hFF) ? 8'hFF : st_base + 8'd1;
      end else if (st_clr) begin
        st_sticky <= 1'b0;
        st_cnt    <= '0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^addr[30:ADDR_W+2];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM access sizes, errors/STATUS, wrap, LED, timer, reset.
module tb_dmem_responder;

  localparam logic [31:0] MM = 32'h8000_0000;

  logic        clk, reset, mem_w, irq, err;
  logic [31:0] addr, din, dout, led;
  logic [2:0]  dm_ctrl;
  int          checks, errors;

  dmem_responder #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .din(din),
    .dm_ctrl(dm_ctrl), .dout(dout), .led(led), .irq(irq), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    @(negedge clk);
    mem_w = 1'b1; addr = a; din = d; dm_ctrl = c;
    @(posedge clk);
    #1 mem_w = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] c);
    @(negedge clk);
    mem_w = 1'b0; addr = a; dm_ctrl = c;
    #1;
  endtask

  task automatic ld_chk(input string tag, input logic [31:0] a, input logic [2:0] c,
                        input logic [31:0] exp);
    ld(a, c);
    chk(tag, dout, exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; mem_w = 1'b0; addr = MM + 32'h4; din = '0; dm_ctrl = 3'b000;
    #2;
    chk("rst_cnt", dout, 32'h0);
    chk("rst_led", led, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    addr = MM + 32'h8;
    #1 chk("rst_status", dout, 32'h0);
    #9 reset = 1'b1;

    // byte lanes
    st(32'h10, 32'h1122_3344, 3'b000);
    st(32'h11, 32'h0000_00AA, 3'b100);
    ld_chk("lw_10", 32'h10, 3'b000, 32'h1122_AA44);
    ld_chk("lb_11", 32'h11, 3'b011, 32'hFFFF_FFAA);
    ld_chk("lbu_11", 32'h11, 3'b100, 32'h0000_00AA);
    ld_chk("lbu_13", 32'h13, 3'b100, 32'h0000_0011);

    // half lanes
    st(32'h20, 32'h1234_5678, 3'b000);
    st(32'h22, 32'h0000_8001, 3'b001);
    ld_chk("lh_22", 32'h22, 3'b001, 32'hFFFF_8001);
    ld_chk("lhu_22", 32'h22, 3'b010, 32'h0000_8001);
    ld_chk("lh_20", 32'h20, 3'b001, 32'h0000_5678);
    ld_chk("lw_20", 32'h20, 3'b000, 32'h8001_5678);

    // read-during-write
    st(32'h30, 32'h0102_0304, 3'b000);
    @(negedge clk);
    mem_w = 1'b1; addr = 32'h30; din = 32'hCAFE_F00D; dm_ctrl = 3'b000;
    #1 chk("rdw_old", dout, 32'h0102_0304);
    @(posedge clk);
    #1 mem_w = 1'b0;
    chk("rdw_new", dout, 32'hCAFE_F00D);

    // misaligned stores
    @(negedge clk);
    mem_w = 1'b1; addr = 32'h13; din = 32'hFFFF_FFFF; dm_ctrl = 3'b000;
    #1 chk("mis_err", {31'b0, err}, 32'h1);
    chk("mis_dout", dout, 32'h0);
    @(posedge clk);
    #1 mem_w = 1'b0;
    ld_chk("mis_ram", 32'h10, 3'b000, 32'h1122_AA44);
    ld_chk("status_1", MM + 32'h8, 3'b000, 32'h0000_0101);
    for (int i = 0; i < 3; i++) st(32'h13, 32'hFFFF_FFFF, 3'b000);
    ld_chk("status_4", MM + 32'h8, 3'b000, 32'h0000_0401);
    st(MM + 32'h8, 32'h0, 3'b000);
    ld_chk("status_clr", MM + 32'h8, 3'b000, 32'h0);

    // error loads: flagged, zero data, no status update
    ld(32'h12, 3'b000);
    chk("ld_mis_err", {31'b0, err}, 32'h1);
    chk("ld_mis_dout", dout, 32'h0);
    ld(32'h10, 3'b111);
    chk("rsvd_err", {31'b0, err}, 32'h1);
    ld(MM, 3'b100);
    chk("mmio_sub_err", {31'b0, err}, 32'h1);
    ld(32'h21, 3'b010);
    chk("half_odd_err", {31'b0, err}, 32'h1);
    ld_chk("status_ld", MM + 32'h8, 3'b000, 32'h0);

    // faulting STATUS store: clear then count the event
    st(32'h13, 32'h0, 3'b000);
    st(MM + 32'h8, 32'h0, 3'b001);
    ld_chk("status_coll", MM + 32'h8, 3'b000, 32'h0000_0101);
    for (int i = 0; i < 260; i++) st(32'h22, 32'h0, 3'b000);
    ld_chk("status_sat", MM + 32'h8, 3'b000, 32'h0000_FF01);
    st(MM + 32'h8, 32'h0, 3'b000);
    ld_chk("status_clr2", MM + 32'h8, 3'b000, 32'h0);
    ld_chk("lw_20_kept", 32'h20, 3'b000, 32'h8001_5678);

    // wrap
    st(32'h1000, 32'hDEAD_BEEF, 3'b000);
    ld_chk("wrap", 32'h0, 3'b000, 32'hDEAD_BEEF);
    ld_chk("wrap_10", 32'h10, 3'b000, 32'h1122_AA44);

    // LED
    st(MM, 32'h5, 3'b000);
    chk("led", led, 32'h5);
    ld_chk("led_rd", MM, 3'b000, 32'h5);

`ifdef DMEM_TIMER_EN
    st(MM + 32'hC, 32'd20, 3'b000);
    st(MM + 32'h4, 32'd0, 3'b000);
    ld_chk("cnt_load", MM + 32'h4, 3'b000, 32'd0);
    for (int i = 0; i < 60; i++) begin
      ld(MM + 32'h4, 3'b000);
      if (dout == 32'd20) break;
    end
    chk("cnt_hit", dout, 32'd20);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("irq_set", {31'b0, irq}, 32'h1);
    ld_chk("cmp_rd", MM + 32'hC, 3'b000, 32'd20);
    ld(32'h0, 3'b000);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    st(MM + 32'hC, 32'd40, 3'b000);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (irq) break;
    end
    chk("irq_again", {31'b0, irq}, 32'h1);
`else
    ld_chk("cnt_off", MM + 32'h4, 3'b000, 32'h0);
    st(MM + 32'hC, 32'd20, 3'b000);
    ld_chk("cmp_off", MM + 32'hC, 3'b000, 32'h0);
    chk("irq_off", {31'b0, irq}, 32'h0);
`endif

    // reset mid-run, between edges
    chk("led_pre_rst", led, 32'h5);
    @(negedge clk);
    mem_w = 1'b0; addr = MM + 32'h4; dm_ctrl = 3'b000; reset = 1'b0;
    #1 chk("mid_rst_cnt", dout, 32'h0);
    chk("mid_rst_led", led, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
`ifdef DMEM_TIMER_EN
    addr = MM + 32'hC;
    #1 chk("mid_rst_cmp", dout, 32'hFFFF_FFFF);
`endif
    #1 reset = 1'b1;
    ld_chk("ram_kept_10", 32'h10, 3'b000, 32'h1122_AA44);
    ld_chk("ram_kept_0", 32'h0, 3'b000, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the single-cycle RISC-V core. Sits at the far end of the core's data port: mem_w, ALU address, store data, dm_ctrl and load data.
- Decodes dm_ctrl into byte, half and word loads/stores on a word-organised RAM.
- Provides a small MMIO window: LED register, cycle counter, compare/IRQ, and misalignment status.
- Reads are combinational, so the core still completes a load in one cycle. Writes commit on the clock edge.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_w  in  1  store strobe from core
- addr  in  32  byte address (core ALU output)
- din  in  32  store data (core rs2 value)
- dm_ctrl  in  3  access size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 reserved
- dout  out  32  load data to core, combinational
- led  out  32  LED register
- irq  out  1  timer interrupt, registered
- err  out  1  misaligned/reserved access this cycle, combinational

Behaviour:
- Reset (reset=0, async) sets:
  - led=0, cycle counter=0, compare=32'hFFFF_FFFF, irq=0, status=0.
  - RAM contents are not reset.
- Address decode:
  - addr[31]=0 selects RAM. Word index is addr[ADDR_W+1:2]; upper bits are ignored, so accesses wrap modulo depth.
  - addr[31]=1 selects MMIO at offset addr[3:0]:
    - 0x0 LED: RW.
    - 0x4 CNT: read returns counter; write loads din.
    - 0x8 STATUS: bit0 sticky misalign, bits[15:8] misalign count; any write clears it.
    - 0xC CMP: RW; a write also clears irq.
    - Other offsets read 0 and ignore writes.
  - MMIO accepts word accesses only. Sub-word MMIO accesses are flagged as errors.
- Misalignment and error conditions (err=1, combinational):
  - word access with addr[1:0]≠0
  - half access with addr[0]=1
  - reserved dm_ctrl
  - sub-word MMIO access
  - On error: dout=0 and any store is suppressed. If the access is a store (mem_w=1), the next edge sets status bit0 and increments the count, saturating at 255.
  - Loads with err=1 do not update status.
- Loads:
  - Word returns the full word.
  - Half selects lane addr[1], then sign- or zero-extends.
  - Byte selects lane addr[1:0], then sign- or zero-extends.
- Stores (mem_w=1, no error), committed at the rising edge:
  - byte writes din[7:0] to lane addr[1:0]
  - half writes din[15:0] to lane addr[1]
  - word writes all 32 bits
  - Other lanes are unchanged.
- Read-during-write: dout shows the old data in the store cycle and the new data from the next cycle.
- Counter:
  - Increments every cycle and wraps from FFFF_FFFF to 0.
  - A CNT write loads din that cycle; the write wins over the increment.
- irq:
  - Set on the edge after counter==compare.
  - Held until a CMP write.
  - If a CMP write and a match occur in the same cycle, the write wins and irq is cleared.
- STATUS write and new store-error in the same cycle: the event wins, giving bit0=1, count=1.
- Reset asserted mid-operation: immediate return to reset values; any pending store is lost.

Optional Feature:
- Macro: DMEM_TIMER_EN.
- Defined: CNT, CMP and irq behave as above.
- Undefined:
  - Counter and compare logic are not built.
  - Reads at 0x4 and 0xC return 0; writes there are ignored.
  - irq is tied 0.
  - LED, STATUS and RAM are unchanged.

Test Plan:
- Byte store, then loads:
  - sw 0x11223344 @0x10; sb 0xAA @0x11 -> lw @0x10 = 0x1122AA44.
  - lb @0x11 = 0xFFFFFFAA; lbu @0x11 = 0x000000AA.
- Half lanes: sh 0x8001 @0x22 -> lh @0x22 = 0xFFFF8001, lhu @0x22 = 0x00008001, lh @0x20 unchanged.
- Misaligned store:
  - sw @0x13: err=1 and RAM word 0x10 unchanged; STATUS reads 0x0101.
  - Three more such stores -> 0x0401.
  - Write STATUS -> 0.
- Wrap: with ADDR_W=10, sw 0xDEADBEEF @0x1000 -> lw @0x0000 = 0xDEADBEEF.
- Timer (DMEM_TIMER_EN):
  - Write CMP=20, CNT=0 -> irq rises on the edge after the counter reads 20.
  - irq stays high until a CMP write; it drops on that edge.
- Reset mid-run: irq=1 and led=0x5, assert reset between edges -> led=0, irq=0, CNT=0 immediately; RAM data from before the reset is still readable.
